// File: rtl/bus_arbiter_if.sv
// Handshake and memory-bus bundle between the two requesters, the arbiter and the memory controller.
// The master modport is the arbiter's view; slave is the requester/memory-controller side.
interface bus_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int BE_W   = 8
);
  logic              inst_req;
  logic [DATA_W-1:0] inst_address;
  logic [DATA_W-1:0] inst_read_data;
  logic              inst_ack;

  logic              data_req;
  logic [DATA_W-1:0] data_address;
  logic [BE_W-1:0]   data_byte_write_enable;
  logic [DATA_W-1:0] data_write_data;
  logic [DATA_W-1:0] data_read_data;
  logic              data_ack;

  logic              mem_transfer_enable;
  logic [DATA_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byte_write_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_transfer_busy;

  logic              bus_error;

  modport master (
    input  inst_req, inst_address, data_req, data_address, data_byte_write_enable,
           data_write_data, mem_read_data, mem_transfer_busy,
    output inst_read_data, inst_ack, data_read_data, data_ack, mem_transfer_enable,
           mem_address, mem_byte_write_enable, mem_write_data, bus_error
  );

  modport slave (
    output inst_req, inst_address, data_req, data_address, data_byte_write_enable,
           data_write_data, mem_read_data, mem_transfer_busy,
    input  inst_read_data, inst_ack, data_read_data, data_ack, mem_transfer_enable,
           mem_address, mem_byte_write_enable, mem_write_data, bus_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory controller, one transfer in flight, with timeout.
// Define ROUND_ROBIN_EN for alternating tie-break; otherwise the data port always wins ties.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic          clock,
  input logic          reset,
  bus_arbiter_if.master bus
);
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       wait_cnt_q;
  logic              owner_data_q;
  logic              error_q;
  logic              grant_data;
  logic              any_req;
  logic              timeout;
  logic              mem_en;
  logic [DATA_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef ROUND_ROBIN_EN
  logic last_data_q;
`endif

  assign any_req = bus.inst_req | bus.data_req;

`ifdef ROUND_ROBIN_EN
  // On a tie the port that did not win last time goes first.
  assign grant_data = bus.data_req & (~bus.inst_req | ~last_data_q);
`else
  assign grant_data = bus.data_req;
`endif

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!bus.mem_transfer_busy) begin
          state_d = DONE;
        end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      owner_data_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_data_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_data_q <= grant_data;
`ifdef ROUND_ROBIN_EN
        last_data_q  <= grant_data;
`endif
      end
      if (state_q == WAIT && bus.mem_transfer_busy) wait_cnt_q <= wait_cnt_q + 16'd1;
      else                                          wait_cnt_q <= '0;
      if (timeout) error_q <= 1'b1;
    end
  end

  // Request fields and read data: outputs are gated by state, so these need no reset.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && any_req) begin
      addr_q  <= grant_data ? bus.data_address : bus.inst_address;
      be_q    <= grant_data ? bus.data_byte_write_enable : '0;
      wdata_q <= grant_data ? bus.data_write_data : '0;
    end
    if (state_q == WAIT) rdata_q <= timeout ? '0 : bus.mem_read_data;
  end

  assign mem_en                    = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.mem_transfer_enable   = mem_en;
  assign bus.mem_address           = mem_en ? addr_q  : '0;
  assign bus.mem_byte_write_enable = mem_en ? be_q    : '0;
  assign bus.mem_write_data        = mem_en ? wdata_q : '0;

  assign bus.inst_ack       = (state_q == DONE) && !owner_data_q;
  assign bus.data_ack       = (state_q == DONE) &&  owner_data_q;
  assign bus.inst_read_data = bus.inst_ack ? rdata_q : '0;
  assign bus.data_read_data = bus.data_ack ? rdata_q : '0;
  assign bus.bus_error      = error_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a default-timeout instance plus a TIMEOUT_CYCLES=4 instance.
module tb_bus_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  bus_arbiter_if bus();
  bus_arbiter_if bus2();

  bus_arbiter #(.TIMEOUT_CYCLES(1023)) dut (.clock(clock), .reset(reset), .bus(bus));
  bus_arbiter #(.TIMEOUT_CYCLES(4))    dut_to (.clock(clock), .reset(reset), .bus(bus2));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_any_ack(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.inst_ack || bus.data_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.inst_ack !== 1'b0 || bus.data_ack !== 1'b0)
      begin errors++; $display("FAIL reset_acks got %b%b exp 00", bus.inst_ack, bus.data_ack); end
    checks++;
    if (bus.mem_transfer_enable !== 1'b0 || bus.mem_address !== 64'h0)
      begin errors++; $display("FAIL reset_mem got en=%b addr=%h exp 0", bus.mem_transfer_enable, bus.mem_address); end
    checks++;
    if (bus.bus_error !== 1'b0 || bus2.bus_error !== 1'b0)
      begin errors++; $display("FAIL reset_error got %b/%b exp 0", bus.bus_error, bus2.bus_error); end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch;
    bus.mem_read_data = 64'hDEADBEEF;
    bus.inst_address  = 64'h100;
    bus.inst_req      = 1'b1;
    tick();
    checks++;
    if (bus.mem_transfer_enable !== 1'b1 || bus.mem_address !== 64'h100 || bus.mem_byte_write_enable !== 8'h00)
      begin errors++; $display("FAIL fetch_issue got en=%b addr=%h be=%h exp 1/100/00", bus.mem_transfer_enable, bus.mem_address, bus.mem_byte_write_enable); end
    tick();
    tick();
    checks++;
    if (bus.inst_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack_n3 got %b exp 1", bus.inst_ack); end
    checks++;
    if (bus.inst_read_data !== 64'hDEADBEEF)
      begin errors++; $display("FAIL fetch_rdata got %h exp deadbeef", bus.inst_read_data); end
    checks++;
    if (bus.data_ack !== 1'b0 || bus.mem_transfer_enable !== 1'b0)
      begin errors++; $display("FAIL fetch_done_misc got dack=%b en=%b exp 0/0", bus.data_ack, bus.mem_transfer_enable); end
    bus.inst_req = 1'b0;
    tick();
    checks++;
    if (bus.inst_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_one_cycle got %b exp 0", bus.inst_ack); end
  endtask

  task automatic test_store;
    int extra;
    bus.data_address           = 64'h0100_0008;
    bus.data_byte_write_enable = 8'hFF;
    bus.data_write_data        = 64'h1234;
    bus.data_req               = 1'b1;
    tick();
    checks++;
    if (bus.mem_address !== 64'h0100_0008 || bus.mem_byte_write_enable !== 8'hFF || bus.mem_write_data !== 64'h1234)
      begin errors++; $display("FAIL store_issue got %h/%h/%h exp 01000008/ff/1234", bus.mem_address, bus.mem_byte_write_enable, bus.mem_write_data); end
    bus.data_address    = 64'hBAD0;
    bus.data_write_data = 64'hBAD1;
    tick();
    checks++;
    if (bus.mem_transfer_enable !== 1'b1 || bus.mem_address !== 64'h0100_0008 || bus.mem_write_data !== 64'h1234)
      begin errors++; $display("FAIL store_wait_latched got en=%b %h/%h exp 1/01000008/1234", bus.mem_transfer_enable, bus.mem_address, bus.mem_write_data); end
    tick();
    checks++;
    if (bus.data_ack !== 1'b1 || bus.inst_ack !== 1'b0)
      begin errors++; $display("FAIL store_ack got d=%b i=%b exp 1/0", bus.data_ack, bus.inst_ack); end
    bus.data_req               = 1'b0;
    bus.data_byte_write_enable = 8'h00;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.data_ack || bus.inst_ack) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL store_single_pulse got %0d extra acks exp 0", extra); end
  endtask

  task automatic test_tie;
    logic [2:0] exp_data;
    int n;
`ifdef ROUND_ROBIN_EN
    exp_data = 3'b010;
`else
    exp_data = 3'b111;
`endif
    bus.inst_address = 64'h300;
    bus.data_address = 64'h400;
    bus.inst_req     = 1'b1;
    bus.data_req     = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_any_ack(n);
      checks++;
      if (n < 0) begin
        errors++; $display("FAIL tie_grant%0d_timeout got no ack exp ack", g);
      end else if (bus.data_ack !== exp_data[g] || bus.inst_ack !== !exp_data[g]) begin
        errors++; $display("FAIL tie_grant%0d got d=%b i=%b exp d=%b", g, bus.data_ack, bus.inst_ack, exp_data[g]);
      end
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    tick();
  endtask

  task automatic test_busy;
    int bad;
    bus.mem_transfer_busy = 1'b1;
    bus.mem_read_data     = 64'h55AA;
    bus.inst_address      = 64'h200;
    bus.inst_req          = 1'b1;
    bad = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (bus.mem_transfer_enable !== 1'b1 || bus.inst_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL busy_enable_held got %0d bad cycles exp 0", bad); end
    bus.mem_transfer_busy = 1'b0;
    tick();
    checks++;
    if (bus.inst_ack !== 1'b1 || bus.inst_read_data !== 64'h55AA)
      begin errors++; $display("FAIL busy_ack_n8 got ack=%b data=%h exp 1/55aa", bus.inst_ack, bus.inst_read_data); end
    bus.inst_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int bad;
    bus2.mem_transfer_busy = 1'b1;
    bus2.mem_read_data     = 64'hFFFF;
    bus2.data_address      = 64'h40;
    bus2.data_req          = 1'b1;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (bus2.data_ack !== 1'b0 || bus2.bus_error !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL timeout_early got %0d bad cycles exp 0", bad); end
    tick();
    checks++;
    if (bus2.data_ack !== 1'b1 || bus2.data_read_data !== 64'h0 || bus2.bus_error !== 1'b1)
      begin errors++; $display("FAIL timeout_abort got ack=%b data=%h err=%b exp 1/0/1", bus2.data_ack, bus2.data_read_data, bus2.bus_error); end
    bus2.data_req          = 1'b0;
    bus2.mem_transfer_busy = 1'b0;
    tick();
    bus2.inst_address = 64'h80;
    bus2.inst_req     = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus2.inst_ack !== 1'b1 || bus2.inst_read_data !== 64'hFFFF || bus2.bus_error !== 1'b1)
      begin errors++; $display("FAIL timeout_sticky got ack=%b data=%h err=%b exp 1/ffff/1", bus2.inst_ack, bus2.inst_read_data, bus2.bus_error); end
    bus2.inst_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int acks;
    bus.mem_transfer_busy = 1'b1;
    bus.inst_address      = 64'h500;
    bus.inst_req          = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus2.bus_error !== 1'b1) begin errors++; $display("FAIL error_before_reset got %b exp 1", bus2.bus_error); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_transfer_enable !== 1'b0 || bus.mem_address !== 64'h0 || bus.inst_ack !== 1'b0 || bus.data_ack !== 1'b0)
      begin errors++; $display("FAIL reset_async got en=%b addr=%h acks=%b%b exp 0", bus.mem_transfer_enable, bus.mem_address, bus.inst_ack, bus.data_ack); end
    checks++;
    if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL reset_clears_error got %b exp 0", bus2.bus_error); end
    bus.inst_req          = 1'b0;
    bus.mem_transfer_busy = 1'b0;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.inst_ack || bus.data_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL reset_no_ack got %0d acks exp 0", acks); end
    bus.mem_read_data = 64'hCAFE;
    bus.data_address  = 64'h600;
    bus.data_req      = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.data_ack !== 1'b1 || bus.data_read_data !== 64'hCAFE)
      begin errors++; $display("FAIL post_reset_xfer got ack=%b data=%h exp 1/cafe", bus.data_ack, bus.data_read_data); end
    bus.data_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.inst_req = 1'b0;  bus.inst_address = '0;
    bus.data_req = 1'b0;  bus.data_address = '0;
    bus.data_byte_write_enable = '0;  bus.data_write_data = '0;
    bus.mem_read_data = '0;  bus.mem_transfer_busy = 1'b0;
    bus2.inst_req = 1'b0; bus2.inst_address = '0;
    bus2.data_req = 1'b0; bus2.data_address = '0;
    bus2.data_byte_write_enable = '0; bus2.data_write_data = '0;
    bus2.mem_read_data = '0; bus2.mem_transfer_busy = 1'b0;
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_busy();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule
